// File: rtl/bit_pattern_matcher.sv
// Serial bit-stream pattern recognizer with runtime-programmable pattern, care mask,
// length and overlap mode. Emits a registered one-cycle match pulse and a saturating count.
module bit_pattern_matcher #(
    parameter int                PAT_W       = 16,
    parameter int                CNT_W       = 8,
    parameter logic [PAT_W-1:0]  PAT_DEFAULT = PAT_W'(5'b1_1011),
    parameter int                LEN_DEFAULT = 5,
    parameter bit                OVL_DEFAULT = 1'b1,
    localparam int               LW          = $clog2(PAT_W) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bit_in,
    input  logic             bit_valid,
    input  logic             cfg_load,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic [PAT_W-1:0] cfg_mask,
    input  logic [LW-1:0]    cfg_len,
    input  logic             cfg_overlap,
    input  logic             cnt_clr,
    output logic             match,
    output logic [CNT_W-1:0] match_cnt,
    output logic             busy_fill
);

    logic [PAT_W-1:0] hist, pattern, mask;
    logic [LW-1:0]    fill, len;
    logic             overlap;

    logic [PAT_W-1:0] hist_next, lenmask;
    logic [LW-1:0]    fill_inc, len_clamped;
    logic             hit;

    always_comb begin
        lenmask = '0;
        for (int i = 0; i < PAT_W; i++)
            lenmask[i] = (i < int'(len));
    end

    always_comb begin
        len_clamped = cfg_len;
        if (cfg_len == '0)
            len_clamped = LW'(1);
        else if (cfg_len > LW'(PAT_W))
            len_clamped = LW'(PAT_W);
    end

    // fill saturates at len; reaching len means the window is fully populated (ARMED)
    assign hist_next = {hist[PAT_W-2:0], bit_in};
    assign fill_inc  = (fill < len) ? fill + LW'(1) : fill;
    assign hit       = bit_valid & ~cfg_load & (fill_inc >= len) &
                       (((hist_next ^ pattern) & mask & lenmask) == '0);
    assign busy_fill = (fill < len);

    always_ff @(posedge clk) begin
        if (rst) begin
            hist    <= '0;
            fill    <= '0;
            pattern <= PAT_DEFAULT;
            mask    <= '1;
            len     <= LW'(LEN_DEFAULT);
            overlap <= OVL_DEFAULT;
            match   <= 1'b0;
        end else if (cfg_load) begin
            pattern <= cfg_pattern;
            mask    <= cfg_mask;
            len     <= len_clamped;
            overlap <= cfg_overlap;
            hist    <= '0;
            fill    <= '0;
            match   <= 1'b0;
        end else if (bit_valid) begin
            hist  <= hist_next;
            fill  <= (hit && !overlap) ? '0 : fill_inc;
            match <= hit;
        end else begin
            match <= 1'b0;
        end
    end

    // Count on the same edge that raises match, so match_cnt and match update together
    always_ff @(posedge clk) begin
        if (rst || cnt_clr)
            match_cnt <= '0;
        else if (hit && match_cnt != '1)
            match_cnt <= match_cnt + CNT_W'(1);
    end

endmodule

// File: tb/tb_bit_pattern_matcher.sv
// Directed bench for bit_pattern_matcher: a driver pushes hand-computed expectations
// per clock, a monitor pops and compares them just after each rising edge.
module tb_bit_pattern_matcher;

    localparam int PAT_W = 16;
    localparam int CNT_W = 2;
    localparam int LW    = $clog2(PAT_W) + 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             bit_in = 1'b0, bit_valid = 1'b0, cfg_load = 1'b0, cnt_clr = 1'b0;
    logic [PAT_W-1:0] cfg_pattern = '0, cfg_mask = '1;
    logic [LW-1:0]    cfg_len = '0;
    logic             cfg_overlap = 1'b1;
    logic             match, busy_fill;
    logic [CNT_W-1:0] match_cnt;

    bit_pattern_matcher #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid),
        .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_mask(cfg_mask),
        .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cnt_clr(cnt_clr),
        .match(match), .match_cnt(match_cnt), .busy_fill(busy_fill)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic             m;
        logic [CNT_W-1:0] c;
        logic             b;
        string            nm;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: one expectation per clock that the driver stepped
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                chk({e.nm, ".match"},     32'(match),     32'(e.m));
                chk({e.nm, ".match_cnt"}, 32'(match_cnt), 32'(e.c));
                chk({e.nm, ".busy_fill"}, 32'(busy_fill), 32'(e.b));
            end
        end
    end

    task automatic step(input logic r, input logic v, input logic b, input logic ld,
                        input logic clr, input logic em, input logic [CNT_W-1:0] ec,
                        input logic eb, input string nm);
        exp_t e;
        @(negedge clk);
        rst = r; bit_valid = v; bit_in = b; cfg_load = ld; cnt_clr = clr;
        e.m = em; e.c = ec; e.b = eb; e.nm = nm;
        sbq.push_back(e);
    endtask

    task automatic vb(input logic b, input logic em, input logic [CNT_W-1:0] ec,
                      input logic eb, input string nm);
        step(1'b0, 1'b1, b, 1'b0, 1'b0, em, ec, eb, nm);
    endtask

    task automatic load(input logic [PAT_W-1:0] p, input logic [PAT_W-1:0] m,
                        input logic [LW-1:0] l, input logic o, input logic clr,
                        input logic [CNT_W-1:0] ec, input string nm);
        cfg_pattern = p; cfg_mask = m; cfg_len = l; cfg_overlap = o;
        step(1'b0, 1'b0, 1'b0, 1'b1, clr, 1'b0, ec, 1'b1, nm);
    endtask

    logic [PAT_W-1:0] lp;

    initial begin
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1, "reset");

        // defaults, overlapping: 1,1,0,1,1,0,1,1
        vb(1, 0, 0, 1, "ov.b1"); vb(1, 0, 0, 1, "ov.b2"); vb(0, 0, 0, 1, "ov.b3");
        vb(1, 0, 0, 1, "ov.b4"); vb(1, 1, 1, 0, "ov.b5"); vb(0, 0, 1, 0, "ov.b6");
        vb(1, 0, 1, 0, "ov.b7"); vb(1, 1, 2, 0, "ov.b8");
        step(0, 0, 0, 0, 1, 0, 0, 0, "ov.clr");

        // non-overlapping, same stream
        load(16'b1_1011, '1, 5, 1'b0, 1'b0, 0, "nov.load");
        vb(1, 0, 0, 1, "nov.b1"); vb(1, 0, 0, 1, "nov.b2"); vb(0, 0, 0, 1, "nov.b3");
        vb(1, 0, 0, 1, "nov.b4"); vb(1, 1, 1, 1, "nov.b5"); vb(0, 0, 1, 1, "nov.b6");
        vb(1, 0, 1, 1, "nov.b7"); vb(1, 0, 1, 1, "nov.b8");
        step(0, 0, 0, 0, 1, 0, 0, 1, "nov.clr");

        // masked pattern 1001, bit 2 don't care
        load(16'b1001, 16'b1011, 4, 1'b1, 1'b0, 0, "msk.load");
        vb(1, 0, 0, 1, "msk.b1"); vb(1, 0, 0, 1, "msk.b2"); vb(0, 0, 0, 1, "msk.b3");
        vb(1, 1, 1, 0, "msk.b4"); vb(1, 0, 1, 0, "msk.b5"); vb(0, 0, 1, 0, "msk.b6");
        vb(0, 0, 1, 0, "msk.b7"); vb(1, 1, 2, 0, "msk.b8");
        load(16'b1001, 16'b1011, 4, 1'b1, 1'b0, 2, "msk.reload");
        vb(1, 0, 2, 1, "msk.n1"); vb(0, 0, 2, 1, "msk.n2"); vb(1, 0, 2, 1, "msk.n3");
        vb(1, 0, 2, 0, "msk.n4");
        step(0, 0, 0, 0, 1, 0, 0, 0, "msk.clr");

        // gaps in bit_valid; bit_in driven high while invalid to catch stray sampling
        load(16'b1_1011, '1, 5, 1'b1, 1'b0, 0, "gap.load");
        vb(1, 0, 0, 1, "gap.v1");
        step(0, 0, 1, 0, 0, 0, 0, 1, "gap.i1"); step(0, 0, 1, 0, 0, 0, 0, 1, "gap.i2");
        vb(1, 0, 0, 1, "gap.v2");
        step(0, 0, 1, 0, 0, 0, 0, 1, "gap.i3");
        vb(0, 0, 0, 1, "gap.v3"); vb(1, 0, 0, 1, "gap.v4");
        step(0, 0, 1, 0, 0, 0, 0, 1, "gap.i4");
        vb(1, 1, 1, 0, "gap.v5");
        step(0, 0, 1, 0, 0, 0, 1, 0, "gap.after");

        // cfg_len=0 clamps to 1: every valid 1 matches; counter saturates at 3
        load(16'b1, '1, 0, 1'b1, 1'b0, 1, "len0.load");
        vb(1, 1, 2, 0, "len0.b1"); vb(0, 0, 2, 0, "len0.b2");
        vb(1, 1, 3, 0, "len0.b3"); vb(1, 1, 3, 0, "len0.b4");

        // cfg_len=PAT_W+3 clamps to PAT_W: only the full 16-bit pattern matches
        lp = 16'hA5C3;
        load(lp, '1, LW'(PAT_W + 3), 1'b1, 1'b1, 0, "clamp.load");
        for (int i = PAT_W - 1; i >= 0; i--)
            vb(lp[i], (i == 0), (i == 0) ? 2'd1 : 2'd0, (i != 0), "clamp.bit");

        // saturation at CNT_W=2 then clear colliding with a match
        load(16'b1, '1, 1, 1'b1, 1'b1, 0, "sat.load");
        vb(1, 1, 1, 0, "sat.m1"); vb(1, 1, 2, 0, "sat.m2"); vb(1, 1, 3, 0, "sat.m3");
        vb(1, 1, 3, 0, "sat.m4"); vb(1, 1, 3, 0, "sat.m5");
        step(0, 1, 1, 0, 1, 1, 0, 0, "sat.clr_vs_match");

        // odd config, then reset mid-stream with a would-be match on the reset cycle
        load(16'b0, '1, 1, 1'b0, 1'b1, 0, "rst.load");
        vb(1, 0, 0, 0, "rst.b1"); vb(1, 0, 0, 0, "rst.b2"); vb(0, 1, 1, 1, "rst.b3");
        vb(1, 0, 1, 0, "rst.b4");
        step(1, 1, 0, 0, 0, 0, 0, 1, "rst.assert");
        vb(1, 0, 0, 1, "rst.d1"); vb(1, 0, 0, 1, "rst.d2"); vb(0, 0, 0, 1, "rst.d3");
        vb(1, 0, 0, 1, "rst.d4"); vb(1, 1, 1, 0, "rst.d5"); vb(0, 0, 1, 0, "rst.d6");
        vb(1, 0, 1, 0, "rst.d7"); vb(1, 1, 2, 0, "rst.d8");

        // cfg_load beats bit_valid on the completing bit; fill restarts from 0
        vb(1, 0, 2, 0, "ld.b1"); vb(1, 0, 2, 0, "ld.b2"); vb(0, 0, 2, 0, "ld.b3");
        vb(1, 0, 2, 0, "ld.b4");
        cfg_pattern = 16'b1_1011; cfg_mask = '1; cfg_len = 5; cfg_overlap = 1'b1;
        step(0, 1, 1, 1, 0, 0, 2, 1, "ld.collide");
        vb(1, 0, 2, 1, "ld.after");

        @(negedge clk);
        bit_valid = 1'b0; cfg_load = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        if (sbq.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", sbq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation still running at 100000, expected done");
        $fatal(1);
    end

endmodule
